// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer and its address checker.
package fetch_ctrl_pkg;

  // Sequencer states: free running, frozen, frozen with a captured redirect.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_HOLD_PEND = 2'd2
  } fetch_state_t;

  // Address map constants; the fetch unit uses DEF_PC_RESET as its reset value too.
  localparam logic [31:0] DEF_PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_TOP     = 32'h0000_6FFC;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  // Sequential successor of a fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] cur);
    return cur + INSN_BYTES;
  endfunction

endpackage

// File: rtl/fetch_addr_chk.sv
// Combinational alignment / range checker for word fetch addresses.
// Also used by the data-memory stage with its own window.
module fetch_addr_chk
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] IM_BASE = DEF_IM_BASE,
  parameter logic [31:0] IM_TOP  = DEF_IM_TOP
) (
  input  logic [31:0] addr,
  output logic        adel
);

  logic misaligned;
  logic below_base;
  logic above_top;

  // Unsigned compares against the legal window plus word alignment.
  always_comb begin
    misaligned = (addr[1:0] != 2'b00);
    below_base = (addr < IM_BASE);
    above_top  = (addr > IM_TOP);
    adel       = misaligned | below_base | above_top;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: selects the next PC among exception entry, eret
// return, a held redirect, a live redirect and sequential fetch, and holds
// one redirect that resolves while the front end is frozen.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = DEF_PC_RESET,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
  parameter logic [31:0] IM_TOP     = DEF_IM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        flush_fd,
  output logic        adel_f,
  output logic        pend_valid
);

  fetch_state_t state_reg;
  fetch_state_t state_next;
  logic [31:0]  pend_target_reg;
  logic [31:0]  pend_target_next;
  logic         br_redirect;

  assign br_redirect = br_valid & br_taken;
  assign pend_valid  = (state_reg == ST_HOLD_PEND);

  // Address error flag for the instruction currently being fetched.
  fetch_addr_chk #(
    .IM_BASE (IM_BASE),
    .IM_TOP  (IM_TOP)
  ) u_addr_chk (
    .addr (pc),
    .adel (adel_f)
  );

  // State and held redirect target register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      pend_target_reg <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pend_target_reg <= pend_target_next;
    end
  end

  // Next-PC arbitration and next-state logic, highest priority first.
  always_comb begin
    state_next       = state_reg;
    pend_target_next = pend_target_reg;
    next_pc          = pc_incr(pc);
    pc_en            = ~stall;
    flush_fd         = 1'b0;

    if (reset) begin
      // Reset dominates; the fetch unit is pointed at the boot address.
      next_pc          = PC_RESET;
      pc_en            = 1'b1;
      flush_fd         = 1'b1;
      state_next       = ST_RUN;
      pend_target_next = 32'h0;
    end else if (exc_req) begin
      // Exception entry ignores the freeze and drops any held redirect;
      // a simultaneous eret is discarded.
      next_pc          = EXC_VECTOR;
      pc_en            = 1'b1;
      flush_fd         = 1'b1;
      state_next       = ST_RUN;
      pend_target_next = 32'h0;
    end else if (eret_req) begin
      next_pc          = epc;
      pc_en            = 1'b1;
      flush_fd         = 1'b1;
      state_next       = ST_RUN;
      pend_target_next = 32'h0;
    end else if (state_reg == ST_HOLD_PEND) begin
      // New branch decisions are ignored while a redirect is held.
      if (!stall) begin
        next_pc          = pend_target_reg;
        pc_en            = 1'b1;
        state_next       = ST_RUN;
        pend_target_next = 32'h0;
      end else begin
        pc_en = 1'b0;
      end
    end else if (br_redirect) begin
      if (!stall) begin
        // Delay slot already in F is kept, so no flush.
        next_pc    = br_target;
        pc_en      = 1'b1;
        state_next = ST_RUN;
      end else begin
        pc_en            = 1'b0;
        pend_target_next = br_target;
        state_next       = ST_HOLD_PEND;
      end
    end else begin
      state_next = stall ? ST_HOLD : ST_RUN;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares them.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic        flush_fd;
  logic        adel_f;
  logic        pend_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        en;
    logic        fl;
    logic        pv;
    logic        ad;
  } exp_t;

  exp_t exp_q[$];

  fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .stall      (stall),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .next_pc    (next_pc),
    .pc_en      (pc_en),
    .flush_fd   (flush_fd),
    .adel_f     (adel_f),
    .pend_valid (pend_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the outputs of the current cycle with the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   bad;
      e   = exp_q.pop_front();
      bad = 0;
      checks++;
      if (next_pc !== e.npc) begin
        $display("FAIL %s next_pc got %h want %h", e.name, next_pc, e.npc);
        bad++;
      end
      checks++;
      if (pc_en !== e.en) begin
        $display("FAIL %s pc_en got %b want %b", e.name, pc_en, e.en);
        bad++;
      end
      checks++;
      if (flush_fd !== e.fl) begin
        $display("FAIL %s flush_fd got %b want %b", e.name, flush_fd, e.fl);
        bad++;
      end
      checks++;
      if (pend_valid !== e.pv) begin
        $display("FAIL %s pend_valid got %b want %b", e.name, pend_valid, e.pv);
        bad++;
      end
      checks++;
      if (adel_f !== e.ad) begin
        $display("FAIL %s adel_f got %b want %b", e.name, adel_f, e.ad);
        bad++;
      end
      errors += bad;
      $display("txn %-14s pc=%h next_pc=%h pc_en=%b flush=%b pend=%b adel=%b %s",
               e.name, pc, next_pc, pc_en, flush_fd, pend_valid, adel_f,
               (bad == 0) ? "ok" : "bad");
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic step(input string name, input logic rst, input logic [31:0] p,
                      input logic stl, input logic bv, input logic bt,
                      input logic [31:0] btgt, input logic exc, input logic eret,
                      input logic [31:0] ep, input logic push,
                      input logic [31:0] x_npc, input logic x_en, input logic x_fl,
                      input logic x_pv, input logic x_ad);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    pc        = p;
    stall     = stl;
    br_valid  = bv;
    br_taken  = bt;
    br_target = btgt;
    exc_req   = exc;
    eret_req  = eret;
    epc       = ep;
    if (push) begin
      e.name = name;
      e.npc  = x_npc;
      e.en   = x_en;
      e.fl   = x_fl;
      e.pv   = x_pv;
      e.ad   = x_ad;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int budget;
    reset = 1'b1; pc = 32'h3000; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_target = 32'h0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;

    //    name            rst pc            stl bv bt tgt           exc er epc          push npc          en fl pv ad
    step("reset0",        1, 32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,     0, 32'h0,       0, 0, 0, 0);
    step("reset1",        1, 32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3000,    1, 1, 0, 0);
    step("seq0",          0, 32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3004,    1, 0, 0, 0);
    step("seq1",          0, 32'h3004,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3008,    1, 0, 0, 0);
    step("seq2",          0, 32'h3008,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h300C,    1, 0, 0, 0);
    step("live_br",       0, 32'h3010,     0, 1, 1, 32'h3100,    0, 0, 32'h0,     1, 32'h3100,    1, 0, 0, 0);
    step("capture",       0, 32'h3010,     1, 1, 1, 32'h3100,    0, 0, 32'h0,     1, 32'h3014,    0, 0, 0, 0);
    step("hold1_br2",     0, 32'h3010,     1, 1, 1, 32'h3200,    0, 0, 32'h0,     1, 32'h3014,    0, 0, 1, 0);
    step("hold2",         0, 32'h3010,     1, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3014,    0, 0, 1, 0);
    step("hold3_br2",     0, 32'h3010,     1, 1, 1, 32'h3200,    0, 0, 32'h0,     1, 32'h3014,    0, 0, 1, 0);
    step("release",       0, 32'h3010,     0, 1, 1, 32'h3200,    0, 0, 32'h0,     1, 32'h3100,    1, 0, 1, 0);
    step("after_rel",     0, 32'h3100,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3104,    1, 0, 0, 0);
    step("cap_for_exc",   0, 32'h3104,     1, 1, 1, 32'h3100,    0, 0, 32'h0,     1, 32'h3108,    0, 0, 0, 0);
    step("held",          0, 32'h3104,     1, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3108,    0, 0, 1, 0);
    step("exc_in_pend",   0, 32'h3104,     1, 0, 0, 32'h0,       1, 0, 32'h0,     1, 32'h4180,    1, 1, 1, 0);
    step("after_exc",     0, 32'h4180,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h4184,    1, 0, 0, 0);
    step("exc_vs_cap",    0, 32'h4184,     1, 1, 1, 32'h3300,    1, 0, 32'h0,     1, 32'h4180,    1, 1, 0, 0);
    step("no_capture",    0, 32'h4180,     1, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h4184,    0, 0, 0, 0);
    step("exc_and_eret",  0, 32'h4180,     0, 0, 0, 32'h0,       1, 1, 32'h3040,  1, 32'h4180,    1, 1, 0, 0);
    step("eret",          0, 32'h4180,     1, 0, 0, 32'h0,       0, 1, 32'h3040,  1, 32'h3040,    1, 1, 0, 0);
    step("br_not_taken",  0, 32'h3040,     0, 1, 0, 32'h3500,    0, 0, 32'h0,     1, 32'h3044,    1, 0, 0, 0);
    step("adel_misalign", 0, 32'h3002,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3006,    1, 0, 0, 1);
    step("adel_below",    0, 32'h2FFC,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3000,    1, 0, 0, 1);
    step("adel_above",    0, 32'h7000,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h7004,    1, 0, 0, 1);
    step("adel_top_ok",   0, 32'h6FFC,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h7000,    1, 0, 0, 0);
    step("wrap",          0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0,      0, 0, 32'h0,     1, 32'h0000,    1, 0, 0, 1);
    step("cap_for_rst",   0, 32'h3000,     1, 1, 1, 32'h3500,    0, 0, 32'h0,     1, 32'h3004,    0, 0, 0, 0);
    step("rst_in_pend",   1, 32'h3000,     1, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3000,    1, 1, 1, 0);
    step("post_rst",      0, 32'h3000,     0, 0, 0, 32'h0,       0, 0, 32'h0,     1, 32'h3004,    1, 0, 0, 0);

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain pending expectations got %0d want 0", exp_q.size());
      errors++;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the five-stage MIPS pipeline. It sits directly in front of the instruction fetch unit and drives that unit's next-PC and enable inputs. It arbitrates four PC sources: sequential, branch/jump redirect, exception entry and `eret` return. It also holds a branch redirect that resolves while the front end is frozen, and flags fetch address errors for the F stage.

## Interface
Parameters:
- `PC_RESET` — default `32'h0000_3000`; PC value after reset.
- `EXC_VECTOR` — default `32'h0000_4180`; exception entry address.
- `IM_BASE` — default `32'h0000_3000`; lowest legal fetch address.
- `IM_TOP` — default `32'h0000_6FFC`; highest legal fetch address.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high.
- `pc` input, 32 bits: current PC from the fetch unit.
- `stall` input, 1 bit: hazard unit freezes F/D this cycle.
- `br_valid` input, 1 bit: D-stage branch/jump decision is valid this cycle, independent of `stall`.
- `br_taken` input, 1 bit: redirect required; qualified by `br_valid`.
- `br_target` input, 32 bits: redirect address; qualified by `br_valid`.
- `exc_req` input, 1 bit: exception taken this cycle.
- `eret_req` input, 1 bit: `eret` committing this cycle.
- `epc` input, 32 bits: return address for `eret`.
- `next_pc` output, 32 bits: value the fetch unit loads when `pc_en` is 1.
- `pc_en` output, 1 bit: fetch unit PC load enable.
- `flush_fd` output, 1 bit: clear the F/D pipeline register this cycle.
- `adel_f` output, 1 bit: fetch address error for the instruction at `pc`.
- `pend_valid` output, 1 bit: a held redirect is waiting to be applied.

## Operation
- States: RUN (no stall, nothing held), HOLD (stall, nothing held), HOLD_PEND (a held redirect exists).
- Sequential default: `next_pc = pc + 4` (32-bit, wraps modulo 2^32); `pc_en = !stall`.
- Priority per cycle: `exc_req` > `eret_req` > held redirect > live redirect > sequential.
- `exc_req`:
  - `next_pc = EXC_VECTOR`, `pc_en = 1` even when `stall` = 1, `flush_fd = 1`.
  - Held redirect is discarded; next state is RUN.
- `eret_req` (no `exc_req`): same as `exc_req` but `next_pc = epc`.
- Live redirect (`br_valid & br_taken`, nothing held, `stall` = 0):
  - `next_pc = br_target`, `pc_en = 1`, `flush_fd = 0` (delay slot already in F is kept).
- Live redirect with `stall` = 1:
  - Capture `br_target` into the pending register; `pc_en = 0`; next state HOLD_PEND.
- HOLD_PEND with `stall` = 0:
  - `next_pc` = pending target, `pc_en = 1`; pending cleared; next state RUN.
- HOLD_PEND with `stall` = 1: hold; `pc_en = 0`.
- In HOLD_PEND any new `br_valid` is ignored; one redirect in flight at most.
- `br_valid & !br_taken` has no effect beyond the sequential default.
- `adel_f = (pc[1:0] != 0) | (pc < IM_BASE) | (pc > IM_TOP)`; unsigned compares; purely combinational.

## Timing
- `next_pc`, `pc_en`, `flush_fd` and `adel_f` are combinational from inputs and state; zero-cycle latency into the fetch unit.
- Only the state register and the 32-bit pending target are sequential, updated on the rising edge.
- Reset (synchronous, wins over all inputs):
  - State RUN, pending target `32'h0`, `pend_valid = 0`.
  - While `reset` = 1, outputs are forced to `next_pc = PC_RESET`, `pc_en = 1`, `flush_fd = 1`.
- Reset asserted in HOLD_PEND discards the held redirect with no residual effect.
- `exc_req` and `eret_req` together: exception wins; `eret` is dropped; the requester guarantees it is not retried.
- `exc_req` in the same cycle a redirect would be captured: no capture; state RUN.
- `pend_valid` = 1 exactly in HOLD_PEND.

## Structure
- Shared package holds:
  - State enum (RUN/HOLD/HOLD_PEND).
  - Constants `PC_RESET`, `EXC_VECTOR`, `IM_BASE`, `IM_TOP`, which also feed the fetch unit's reset value.
- Sub-module `fetch_addr_chk`: combinational `adel_f` range/alignment checker, reused by the data-memory stage.

## Test plan
- Reset, then 3 cycles with no requests: `pc_en` = 1; `next_pc` = 0x3004, 0x3008, 0x300C as `pc` advances; `flush_fd` = 0.
- `pc` = 0x3010, `br_valid` = `br_taken` = 1, `br_target` = 0x3100, `stall` = 0: `next_pc` = 0x3100, `pc_en` = 1, `flush_fd` = 0.
- Same redirect with `stall` = 1 for 3 cycles, then `stall` = 0:
  - `pc_en` = 0 and `pend_valid` = 1 for 3 cycles.
  - Release cycle `next_pc` = 0x3100, `pc_en` = 1; `pend_valid` = 0 afterwards.
  - A second `br_valid` (target 0x3200) during the hold is ignored.
- HOLD_PEND plus `exc_req` = 1 with `stall` = 1: `next_pc` = 0x4180, `pc_en` = 1, `flush_fd` = 1; next cycle `pend_valid` = 0.
- `exc_req` and `eret_req` together with `epc` = 0x3040: `next_pc` = 0x4180; then `eret_req` alone gives `next_pc` = 0x3040 with `flush_fd` = 1.
- `pc` = 0x3002, 0x2FFC, 0x7000, 0x6FFC: `adel_f` = 1, 1, 1, 0.
